// File: rtl/decode_regfile.sv
// Decode stage with an integrated register file, a write-back bypass and a busy-bit
// scoreboard; one registered output bundle behind a valid/ready handshake.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ra_o,
    output logic [XLEN-1:0] rb_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      itype_o,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_U = 7'b0110111;

    localparam logic [4:0] ITYPE_R   = 5'b00001;
    localparam logic [4:0] ITYPE_I   = 5'b00010;
    localparam logic [4:0] ITYPE_S   = 5'b00100;
    localparam logic [4:0] ITYPE_U   = 5'b01000;
    localparam logic [4:0] ITYPE_ILL = 5'b10000;

    logic [XLEN-1:0]  r_rf [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_ra, r_rb, r_imm;
    logic [4:0]       r_rd, r_itype;

    logic [4:0]       w_rs1, w_rs2, w_rd;
    logic             w_use_rs1, w_use_rs2, w_use_rd;
    logic [4:0]       w_itype;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm, w_ra, w_rb, w_rs1_val, w_rs2_val;
    logic [4:0]       w_rd_out;
    logic             w_wb_we, w_hazard, w_accept;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_unused_funct3;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    assign w_rs1           = ir_i[19:15];
    assign w_rs2           = ir_i[24:20];
    assign w_rd            = ir_i[11:7];
    assign w_unused_funct3 = ^ir_i[14:12];
    assign w_wb_we         = wb_en && (wb_addr != 5'd0) && idx_ok(wb_addr);

    always_comb begin : decode
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_itype   = ITYPE_ILL;
        w_imm32   = '0;
        case (ir_i[6:0])
            OP_R: begin
                w_itype   = ITYPE_R;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
            end
            OP_I: begin
                w_itype   = ITYPE_I;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_imm32   = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OP_S: begin
                w_itype   = ITYPE_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            OP_U: begin
                w_itype  = ITYPE_U;
                w_use_rd = 1'b1;
                w_imm32  = {ir_i[31:12], 12'b0};
            end
            default: ;
        endcase
        // An index beyond the implemented file makes the whole instruction illegal.
        if ((w_use_rs1 && !idx_ok(w_rs1)) || (w_use_rs2 && !idx_ok(w_rs2)) ||
            (w_use_rd && !idx_ok(w_rd))) begin
            w_itype   = ITYPE_ILL;
            w_use_rs1 = 1'b0;
            w_use_rs2 = 1'b0;
            w_use_rd  = 1'b0;
            w_imm32   = '0;
        end
        w_imm        = {XLEN{w_imm32[31]}};
        w_imm[31:0]  = w_imm32;
        w_ra         = w_use_rs1 ? w_rs1_val : '0;
        w_rb         = w_use_rs2 ? w_rs2_val : '0;
        w_rd_out     = w_use_rd ? w_rd : 5'd0;
    end

    // Read ports forward a same-cycle write-back so the bundle never sees stale data.
    always_comb begin : read_ports
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0 && idx_ok(w_rs1)) begin
            if (w_wb_we && wb_addr == w_rs1) w_rs1_val = wb_data;
            else                             w_rs1_val = r_rf[w_rs1[AW-1:0]];
        end
        if (w_rs2 != 5'd0 && idx_ok(w_rs2)) begin
            if (w_wb_we && wb_addr == w_rs2) w_rs2_val = wb_data;
            else                             w_rs2_val = r_rf[w_rs2[AW-1:0]];
        end
    end

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload while valid && !ready, and the output bundle
    // stays frozen while out_valid && !out_ready.
    always_comb begin : hazard_and_handshake
        w_hazard = (w_use_rs1 && r_busy[w_rs1[AW-1:0]] && !(w_wb_we && wb_addr == w_rs1)) ||
                   (w_use_rs2 && r_busy[w_rs2[AW-1:0]] && !(w_wb_we && wb_addr == w_rs2));
        in_ready = (!r_out_valid || out_ready) && !w_hazard;
        w_accept = in_valid && in_ready;
    end

    // Set is applied after clear so a simultaneous set/clear leaves the bit set.
    always_comb begin : busy_next
        w_busy_nxt = r_busy;
        if (w_wb_we) w_busy_nxt[wb_addr[AW-1:0]] = 1'b0;
        if (w_accept && w_use_rd && w_rd != 5'd0) w_busy_nxt[w_rd[AW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_wb_we) begin
            r_rf[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_itype     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_ra        <= w_ra;
            r_rb        <= w_rb;
            r_imm       <= w_imm;
            r_rd        <= w_rd_out;
            r_itype     <= w_itype;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ra_o      = r_ra;
    assign rb_o      = r_rb;
    assign imm_o     = r_imm;
    assign rd_o      = r_rd;
    assign itype_o   = r_itype;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: a 32-register instance for the main flow and a
// 16-register instance for out-of-range index handling.
module tb_decode_regfile;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     ir_i = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] ra_o, rb_o, imm_o;
    logic [4:0]      rd_o, itype_o;
    logic            wb_en = 1'b0;
    logic [4:0]      wb_addr = '0;
    logic [XLEN-1:0] wb_data = '0;

    logic            in_valid_16 = 1'b0;
    logic            in_ready_16;
    logic [31:0]     ir_16 = '0;
    logic            out_valid_16;
    logic            out_ready_16 = 1'b1;
    logic [XLEN-1:0] ra_16, rb_16, imm_16;
    logic [4:0]      rd_16, itype_16;
    logic            wb_en_16 = 1'b0;
    logic [4:0]      wb_addr_16 = '0;
    logic [XLEN-1:0] wb_data_16 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_regfile #(.XLEN(XLEN), .NREGS(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .ir_i(ir_i),
        .out_valid(out_valid), .out_ready(out_ready), .ra_o(ra_o), .rb_o(rb_o),
        .imm_o(imm_o), .rd_o(rd_o), .itype_o(itype_o), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    decode_regfile #(.XLEN(XLEN), .NREGS(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .ir_i(ir_16), .out_valid(out_valid_16), .out_ready(out_ready_16), .ra_o(ra_16),
        .rb_o(rb_16), .imm_o(imm_16), .rd_o(rd_16), .itype_o(itype_16),
        .wb_en(wb_en_16), .wb_addr(wb_addr_16), .wb_data(wb_data_16)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_itype", itype_o, 0);
        check("rst_ra", ra_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_rd", rd_o, 0);
        reset = 1'b1;
        tick();

        // wb x5, then add x6,x5,x0
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        in_valid = 1'b1; ir_i = enc_r(5'd6, 5'd5, 5'd0);
        #1 check("add_in_ready", in_ready, 1);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_ra", ra_o, 32'h1234);
        check("add_rb", rb_o, 0);
        check("add_itype", itype_o, 5'b00001);
        check("add_rd", rd_o, 6);

        // addi x7,x0,-1
        ir_i = enc_i(5'd7, 5'd0, 12'hFFF);
        tick();
        check("addi_imm", imm_o, 32'hFFFF_FFFF);
        check("addi_itype", itype_o, 5'b00010);
        check("addi_rd", rd_o, 7);

        // add x8,x7,x7 blocked until x7 write-back, which is bypassed
        ir_i = enc_r(5'd8, 5'd7, 5'd7);
        #1 check("haz_in_ready0", in_ready, 0);
        tick();
        check("haz_out_valid_drop", out_valid, 0);
        check("haz_in_ready_still0", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1 check("haz_in_ready_wb", in_ready, 1);
        tick();
        wb_en = 1'b0;
        check("byp_out_valid", out_valid, 1);
        check("byp_ra", ra_o, 32'h55);
        check("byp_rb", rb_o, 32'h55);
        check("byp_rd", rd_o, 8);

        // addi x9 accepted while x9 is written back: busy must remain set
        ir_i = enc_i(5'd9, 5'd0, 12'h001);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1 check("setclr_in_ready", in_ready, 1);
        tick();
        wb_en = 1'b0;
        check("setclr_imm", imm_o, 1);
        check("setclr_rd", rd_o, 9);
        ir_i = enc_r(5'd10, 5'd9, 5'd0);
        #1 check("setclr_busy_haz", in_ready, 0);

        // Illegal opcode with a busy rs1 field is not held back
        ir_i = {12'h000, 5'd9, 3'b000, 5'd0, 7'b1111111};
        #1 check("ill_in_ready", in_ready, 1);
        tick();
        check("ill_itype", itype_o, 5'b10000);
        check("ill_ra", ra_o, 0);
        check("ill_imm", imm_o, 0);

        // sw x7,-4(x5)
        ir_i = enc_s(5'd5, 5'd7, 12'hFFC);
        tick();
        check("sw_imm", imm_o, 32'hFFFF_FFFC);
        check("sw_rd", rd_o, 0);
        check("sw_itype", itype_o, 5'b00100);
        check("sw_ra", ra_o, 32'h1234);
        check("sw_rb", rb_o, 32'h55);
        // sw's rd field is 28; it must not have become busy
        ir_i = enc_r(5'd12, 5'd28, 5'd0);
        #1 check("sw_no_busy", in_ready, 1);
        tick();

        // lui x1,0x80000
        ir_i = enc_u(5'd1, 20'h80000);
        tick();
        check("lui_imm", imm_o, 32'h8000_0000);
        check("lui_itype", itype_o, 5'b01000);
        check("lui_rd", rd_o, 1);

        // Back-pressure for 3 cycles, then 4 bundles back to back
        ir_i = enc_i(5'd13, 5'd0, 12'h123);
        tick();
        out_ready = 1'b0;
        ir_i = enc_i(5'd14, 5'd0, 12'd5);
        #1 check("bp_in_ready0", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_imm", imm_o, 32'h123);
            check("bp_rd", rd_o, 13);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ir_i = enc_i(5'(14 + k), 5'd0, 12'(5 + k));
            #1 check("b2b_in_ready", in_ready, 1);
            tick();
            check("b2b_out_valid", out_valid, 1);
            check("b2b_rd", rd_o, 64'(14 + k));
            check("b2b_imm", imm_o, 64'(5 + k));
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", out_valid, 0);

        // Reset with a held bundle and x9 still busy
        out_ready = 1'b0;
        in_valid = 1'b1; ir_i = enc_i(5'd18, 5'd0, 12'h001);
        tick();
        in_valid = 1'b0;
        check("pre_rst_out_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_itype", itype_o, 0);
        check("async_rst_imm", imm_o, 0);
        check("async_rst_rd", rd_o, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; ir_i = enc_r(5'd1, 5'd9, 5'd9);
        #1 check("post_rst_in_ready", in_ready, 1);
        tick();
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_ra", ra_o, 0);
        check("post_rst_itype", itype_o, 5'b00001);
        ir_i = enc_r(5'd2, 5'd5, 5'd0);
        tick();
        check("post_rst_rf_clear", ra_o, 0);
        in_valid = 1'b0;

        // NREGS=16 instance: out-of-range indices
        wb_en_16 = 1'b1; wb_addr_16 = 5'd3; wb_data_16 = 32'hAB;
        tick();
        wb_addr_16 = 5'd0; wb_data_16 = 32'hDEAD;
        tick();
        wb_addr_16 = 5'd17; wb_data_16 = 32'hBEEF;
        tick();
        wb_en_16 = 1'b0;
        in_valid_16 = 1'b1; ir_16 = enc_r(5'd20, 5'd1, 5'd2);
        #1 check("n16_ill_in_ready", in_ready_16, 1);
        tick();
        check("n16_ill_itype", itype_16, 5'b10000);
        check("n16_ill_rd", rd_16, 0);
        ir_16 = enc_r(5'd6, 5'd4, 5'd0);
        #1 check("n16_no_busy", in_ready_16, 1);
        tick();
        ir_16 = enc_r(5'd7, 5'd1, 5'd0);
        tick();
        check("n16_wb17_ignored", ra_16, 0);
        ir_16 = enc_r(5'd8, 5'd0, 5'd3);
        tick();
        check("n16_x0_reads0", ra_16, 0);
        check("n16_x3", rb_16, 32'hAB);
        in_valid_16 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_regfile.md
DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width (legal values 32 or 64).
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the architectural register count (power of two, 2..32); derived AW = clog2(NREGS).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port in_valid  input  1  ir_i carries an instruction.
REQ-006 The block SHALL have port in_ready  output  1  block accepts ir_i this cycle.
REQ-007 The block SHALL have port ir_i  input  32  instruction word.
REQ-008 The block SHALL have port out_valid  output  1  decoded bundle valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the bundle.
REQ-010 The block SHALL have port ra_o  output  XLEN  rs1 operand.
REQ-011 The block SHALL have port rb_o  output  XLEN  rs2 operand.
REQ-012 The block SHALL have port imm_o  output  XLEN  sign-extended immediate.
REQ-013 The block SHALL have port rd_o  output  5  destination index.
REQ-014 The block SHALL have port itype_o  output  5  one-hot class: R=00001, I=00010, S=00100, U=01000, ILLEGAL=10000.
REQ-015 The block SHALL have port wb_en  input  1  write-back strobe.
REQ-016 The block SHALL have port wb_addr  input  5  write-back index.
REQ-017 The block SHALL have port wb_data  input  XLEN  write-back data.

Function
REQ-018 Register x0 SHALL read 0 always; writes to index 0 SHALL be ignored.
REQ-019 Opcode ir_i[6:0]: 0110011=R, 0010011=I, 0100011=S, 0110111=U; any other opcode, or any used index (rs1/rs2/rd per class) >= NREGS, SHALL decode as ILLEGAL.
REQ-020 imm_o SHALL be: I sign-extend ir[31:20]; S sign-extend {ir[31:25],ir[11:7]}; U {ir[31:12],12'b0} sign-extended to XLEN; R and ILLEGAL 0.
REQ-021 ra_o SHALL be rf[rs1] for R/I/S, else 0; rb_o SHALL be rf[rs2] for R/S, else 0; rd_o SHALL be ir[11:7] for R/I/U, else 0.
REQ-022 Write-back with wb_en=1, wb_addr!=0, wb_addr<NREGS SHALL update rf[wb_addr] at the clock edge; wb_addr>=NREGS SHALL be ignored.
REQ-023 Operand read SHALL bypass a same-cycle write-back to the same index (new wb_data captured).
REQ-024 A scoreboard SHALL hold one busy bit per register: set when an R/I/U instruction with rd!=0 is accepted; cleared by write-back to that index.
REQ-025 Simultaneous set and clear of the same busy bit SHALL leave it set.
REQ-026 Hazard SHALL be: any used source index busy and not being written back this cycle.
REQ-027 in_ready SHALL equal (!out_valid || out_ready) && !hazard; ILLEGAL instructions SHALL NOT be blocked by hazard.
REQ-028 Accept (in_valid && in_ready) SHALL load the output register; out_valid SHALL rise the next cycle (latency 1).
REQ-029 out_valid && !out_ready SHALL hold all outputs stable; accept with out_ready=1 SHALL allow back-to-back throughput of 1/cycle.
REQ-030 out_valid SHALL fall after out_valid && out_ready when no new accept occurs in the same cycle.

Reset
REQ-031 reset=0 SHALL immediately clear all registers, all busy bits, out_valid, ra_o, rb_o, imm_o, rd_o, and set itype_o=00000, independent of clk.
REQ-032 reset asserted mid-transfer SHALL discard the held bundle; in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Reset, then wb x5=0x1234; decode add x6,x5,x0 -> next cycle out_valid=1, ra_o=0x1234, rb_o=0, itype_o=00001, rd_o=6.
REQ-034 Decode addi x7,x0,-1 -> imm_o=0xFFFFFFFF, itype_o=00010; then add x8,x7,x7 with no wb -> in_ready=0 until wb x7 arrives; same-cycle wb 0x55 -> accepted, ra_o=rb_o=0x55.
REQ-035 Decode sw (opcode 0100011, imm=-4) -> imm_o=0xFFFFFFFC, rd_o=0, no busy bit set; lui x1,0x80000 -> imm_o=0x80000000.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; then out_ready=1 every cycle with 4 hazard-free instructions -> 4 bundles on 4 consecutive cycles.
REQ-037 NREGS=16: add x20,x1,x2 -> itype_o=10000, no busy set; wb to x0 and x17 -> no state change, x0 reads 0.
REQ-038 Assert reset while out_valid=1 and x9 busy -> out_valid=0 immediately; after release add x1,x9,x9 accepted at once with ra_o=0.
